intl_collector: RTL



---
 rtl/intl_pkg.sv | 22 ++
 rtl/intl_debounce.sv | 36 +++
 rtl/intl_collector.sv | 121 ++++++++++++
 3 files changed

// File: rtl/intl_pkg.sv
// Shared definitions for the interlock collector: FSM states, channel indices
// and the first-fault code reserved for a software-forced interlock.
package intl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FAULT = 2'd1,
      ST_CLR   = 2'd2
   } intl_state_t;

   localparam int unsigned INTL_REGU = 0;
   localparam int unsigned INTL_OC   = 1;
   localparam int unsigned INTL_OV   = 2;
   localparam int unsigned INTL_OT   = 3;
   localparam int unsigned INTL_EXT  = 4;

   // The code one past the last real channel marks a software-forced trip.
   function automatic int unsigned intl_sw_code(input int unsigned n_intl);
      return n_intl;
   endfunction

endpackage

// File: rtl/intl_debounce.sv
// One interlock channel: input register, saturating run-length counter and
// the masked, debounced detect output.
module intl_debounce #(
   parameter int DEB_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_raw,
   input  logic             i_mask,
   input  logic [DEB_W-1:0] i_deb_cnt,
   output logic             o_det
);

   logic             raw_q;
   logic [DEB_W-1:0] cnt;
   logic             qual;

   assign qual  = raw_q & i_mask;
   assign o_det = qual & (cnt >= i_deb_cnt);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         raw_q <= 1'b0;
         cnt   <= '0;
      end else begin
         raw_q <= i_raw;
         if (qual) begin
            if (cnt != '1)
               cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/intl_collector.sv
// Interlock collector: debounces, masks and latches all interlock sources,
// records the first fault and drives the global PWM interlock.
// Optional fault timestamp is built when INTL_TIMESTAMP_EN is defined.
module intl_collector
   import intl_pkg::*;
#(
   parameter int N_INTL = 8,
   parameter int DEB_W  = 16,
   parameter int FF_W   = $clog2(N_INTL + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [N_INTL-1:0] i_intl_raw,
   input  logic [N_INTL-1:0] i_intl_mask,
   input  logic [DEB_W-1:0]  i_deb_cnt,
   input  logic              i_sw_intl,
   input  logic              i_clr,
   output logic              o_intl,
   output logic [N_INTL-1:0] o_intl_latch,
   output logic [FF_W-1:0]   o_first_fault,
   output logic              o_clr_nack,
   output logic [1:0]        o_state,
   output logic [31:0]       o_fault_ts
);

   localparam logic [FF_W-1:0] FF_SW = FF_W'(intl_sw_code(N_INTL));

   intl_state_t       state;
   logic [N_INTL-1:0] det;
   logic [FF_W-1:0]   first_idx;
   logic              first_found;
   logic              trip;

   for (genvar k = 0; k < N_INTL; k++) begin : g_ch
      intl_debounce #(.DEB_W(DEB_W)) u_deb (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_raw     (i_intl_raw[k]),
         .i_mask    (i_intl_mask[k]),
         .i_deb_cnt (i_deb_cnt),
         .o_det     (det[k])
      );
   end

   // Lowest-numbered detecting channel wins the first-fault record.
   always_comb begin
      first_idx   = '0;
      first_found = 1'b0;
      for (int unsigned k = 0; k < N_INTL; k++) begin
         if (det[k] && !first_found) begin
            first_idx   = FF_W'(k);
            first_found = 1'b1;
         end
      end
   end

   assign trip    = (state == ST_IDLE) && ((|det) || i_sw_intl);
   assign o_state = state;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state         <= ST_IDLE;
         o_intl        <= 1'b0;
         o_intl_latch  <= '0;
         o_first_fault <= '0;
         o_clr_nack    <= 1'b0;
      end else begin
         o_clr_nack <= 1'b0;
         case (state)
            ST_IDLE: begin
               o_intl_latch <= o_intl_latch | det;
               if (trip) begin
                  state         <= ST_FAULT;
                  o_intl        <= 1'b1;
                  o_first_fault <= (|det) ? first_idx : FF_SW;
               end
            end
            ST_FAULT: begin
               o_intl_latch <= o_intl_latch | det;
               if (i_clr) begin
                  if ((|det) || i_sw_intl)
                     o_clr_nack <= 1'b1;
                  else
                     state <= ST_CLR;
               end
            end
            ST_CLR: begin
               o_intl_latch  <= '0;
               o_first_fault <= '0;
               o_intl        <= 1'b0;
               state         <= ST_IDLE;
            end
            default: begin
               o_intl_latch <= o_intl_latch | det;
               o_intl       <= 1'b0;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef INTL_TIMESTAMP_EN
   logic [31:0] ts_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         ts_cnt     <= '0;
         o_fault_ts <= '0;
      end else begin
         ts_cnt <= ts_cnt + 32'd1;
         if (trip)
            o_fault_ts <= ts_cnt;
         else if (state == ST_CLR)
            o_fault_ts <= '0;
      end
   end
`else
   assign o_fault_ts = '0;
`endif

endmodule
